// File: rtl/vga_sync_receiver_pkg.sv
// Shared constants, state encoding and counter helper for the VGA sync receiver.
package vga_sync_receiver_pkg;

    localparam int COUNT_W = 10;
    localparam int ERR_W   = 8;

    localparam int DEF_VIDEO_WIDTH = 3;
    localparam int DEF_TOTAL_COLS  = 800;
    localparam int DEF_TOTAL_ROWS  = 521;
    localparam int DEF_ACTIVE_COLS = 640;
    localparam int DEF_ACTIVE_ROWS = 480;
    localparam int DEF_LOCK_FRAMES = 2;

    typedef logic [COUNT_W-1:0] count_t;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } rx_state_e;

    function automatic count_t sat_inc(input count_t v);
        return (v == '1) ? v : v + count_t'(1);
    endfunction

endpackage

// File: rtl/vga_edge_detect.sv
// Rising-edge detector: compares the live input against its registered history.
module vga_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_rise
);

    logic sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= i_sig;
        end
    end

    assign o_rise = i_sig & ~sig_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA receive side: recovers column/row from HSync/VSync, checks frame geometry,
// locks after consecutive clean frames and emits registered, gated pixel data.
module vga_sync_receiver
    import vga_sync_receiver_pkg::*;
#(
    parameter int VIDEO_WIDTH = DEF_VIDEO_WIDTH,
    parameter int TOTAL_COLS  = DEF_TOTAL_COLS,
    parameter int TOTAL_ROWS  = DEF_TOTAL_ROWS,
    parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
    parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS,
    parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic                   i_HSync,
    input  logic                   i_VSync,
    input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
    output logic [COUNT_W-1:0]     o_Col_Count,
    output logic [COUNT_W-1:0]     o_Row_Count,
    output logic [VIDEO_WIDTH-1:0] o_Red_Video,
    output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
    output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
    output logic                   o_Pixel_Valid,
    output logic                   o_Frame_Start,
    output logic                   o_Locked,
    output logic [ERR_W-1:0]       o_Err_Count
);

    localparam count_t     LAST_COL  = count_t'(TOTAL_COLS - 1);
    localparam count_t     LAST_ROW  = count_t'(TOTAL_ROWS - 1);
    localparam count_t     ACT_COLS  = count_t'(ACTIVE_COLS);
    localparam count_t     ACT_ROWS  = count_t'(ACTIVE_ROWS);
    localparam logic [3:0] LOCK_GOOD = 4'(LOCK_FRAMES);

    // Index 0 = HSync, index 1 = VSync
    logic [1:0] sync_in;
    logic [1:0] sync_rise;
    logic       hs_rise;
    logic       vs_rise;

    assign sync_in = {i_VSync, i_HSync};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_edge
            vga_edge_detect u_edge (
                .clk    (i_Clk),
                .rst_n  (i_Rst_L),
                .i_sig  (sync_in[gi]),
                .o_rise (sync_rise[gi])
            );
        end
    endgenerate

    assign hs_rise = sync_rise[0];
    assign vs_rise = sync_rise[1];

    rx_state_e              state_q, state_d;
    logic [3:0]             good_q, good_d;
    count_t                 col_q, col_d;
    count_t                 row_q, row_d;
    logic [ERR_W-1:0]       err_q, err_d;
    logic                   locked_q, locked_d;
    logic                   valid_q, valid_d;
    logic                   fs_q, fs_d;
    logic [VIDEO_WIDTH-1:0] red_q, red_d;
    logic [VIDEO_WIDTH-1:0] grn_q, grn_d;
    logic [VIDEO_WIDTH-1:0] blu_q, blu_d;
    logic                   line_err;
    logic                   frame_err;
    logic                   geom_err;

    always_comb begin
        col_d = hs_rise ? '0 : sat_inc(col_q);

        row_d = row_q;
        if (vs_rise) begin
            row_d = '0;
        end else if (hs_rise) begin
            row_d = sat_inc(row_q);
        end

        // Timeouts fire only on the step onto TOTAL_COLS/ROWS, so each is flagged once
        line_err  = (hs_rise && (col_q != LAST_COL)) ||
                    (!hs_rise && (col_q == LAST_COL));
        frame_err = (vs_rise && (row_q != LAST_ROW)) ||
                    (hs_rise && !vs_rise && (row_q == LAST_ROW));
        geom_err  = line_err || frame_err;

        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            ST_SEARCH: begin
                good_d = '0;
                if (vs_rise) begin
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (geom_err) begin
                    state_d = ST_SEARCH;
                    good_d  = '0;
                end else if (vs_rise) begin
                    good_d = good_q + 4'd1;
                    if ((good_q + 4'd1) == LOCK_GOOD) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (geom_err) begin
                    state_d = ST_SEARCH;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                good_d  = '0;
            end
        endcase

        err_d = err_q;
        if (geom_err && (state_q != ST_SEARCH) && (err_q != '1)) begin
            err_d = err_q + 8'd1;
        end

        // Gate on next-state values so data lines up with the registered counts
        locked_d = (state_d == ST_LOCKED);
        valid_d  = locked_d && (col_d < ACT_COLS) && (row_d < ACT_ROWS);
        fs_d     = vs_rise;
        red_d    = valid_d ? i_Red_Video : '0;
        grn_d    = valid_d ? i_Grn_Video : '0;
        blu_d    = valid_d ? i_Blu_Video : '0;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q  <= ST_SEARCH;
            good_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            err_q    <= '0;
            locked_q <= 1'b0;
            valid_q  <= 1'b0;
            fs_q     <= 1'b0;
            red_q    <= '0;
            grn_q    <= '0;
            blu_q    <= '0;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            col_q    <= col_d;
            row_q    <= row_d;
            err_q    <= err_d;
            locked_q <= locked_d;
            valid_q  <= valid_d;
            fs_q     <= fs_d;
            red_q    <= red_d;
            grn_q    <= grn_d;
            blu_q    <= blu_d;
        end
    end

    assign o_Col_Count   = col_q;
    assign o_Row_Count   = row_q;
    assign o_Red_Video   = red_q;
    assign o_Grn_Video   = grn_q;
    assign o_Blu_Video   = blu_q;
    assign o_Pixel_Valid = valid_q;
    assign o_Frame_Start = fs_q;
    assign o_Locked      = locked_q;
    assign o_Err_Count   = err_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a shrunken 20x12 frame (16x10 active).
module tb_vga_sync_receiver;

    localparam int VW = 3;
    localparam int TC = 20;
    localparam int TR = 12;
    localparam int AC = 16;
    localparam int AR = 10;
    localparam int LF = 2;

    localparam logic [VW-1:0] RED_PIX = 3'b101;
    localparam logic [VW-1:0] GRN_PIX = 3'b011;
    localparam logic [VW-1:0] BLU_PIX = 3'b110;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          hsync = 1'b0;
    logic          vsync = 1'b0;
    logic [VW-1:0] red_in = '0;
    logic [VW-1:0] grn_in = '0;
    logic [VW-1:0] blu_in = '0;

    logic [9:0]    col_out;
    logic [9:0]    row_out;
    logic [VW-1:0] red_out;
    logic [VW-1:0] grn_out;
    logic [VW-1:0] blu_out;
    logic          valid_out;
    logic          fs_out;
    logic          locked_out;
    logic [7:0]    err_out;

    int checks = 0;
    int errors = 0;

    int   n_valid, n_fs, n_pos_bad, n_win_bad, n_rgb_bad;
    logic lock_first, lock_short_end, lock_after_short;

    always #5 clk = ~clk;

    vga_sync_receiver #(
        .VIDEO_WIDTH (VW),
        .TOTAL_COLS  (TC),
        .TOTAL_ROWS  (TR),
        .ACTIVE_COLS (AC),
        .ACTIVE_ROWS (AR),
        .LOCK_FRAMES (LF)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_L       (rst_n),
        .i_HSync       (hsync),
        .i_VSync       (vsync),
        .i_Red_Video   (red_in),
        .i_Grn_Video   (grn_in),
        .i_Blu_Video   (blu_in),
        .o_Col_Count   (col_out),
        .o_Row_Count   (row_out),
        .o_Red_Video   (red_out),
        .o_Grn_Video   (grn_out),
        .o_Blu_Video   (blu_out),
        .o_Pixel_Valid (valid_out),
        .o_Frame_Start (fs_out),
        .o_Locked      (locked_out),
        .o_Err_Count   (err_out)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // One frame of rows; short_row (if >= 0) lasts short_len clocks instead of TC.
    task automatic drive_frame(input int rows, input int short_row, input int short_len);
        int len;
        logic exp_win;
        n_valid = 0; n_fs = 0; n_pos_bad = 0; n_win_bad = 0; n_rgb_bad = 0;
        lock_first = 1'b0; lock_short_end = 1'b0; lock_after_short = 1'b0;
        for (int r = 0; r < rows; r++) begin
            len = (r == short_row) ? short_len : TC;
            for (int c = 0; c < len; c++) begin
                hsync  = (c < 3);
                vsync  = (r < 2);
                red_in = RED_PIX;
                grn_in = GRN_PIX;
                blu_in = BLU_PIX;
                @(posedge clk);
                #1;
                if (r == 0 && c == 0) lock_first = locked_out;
                if (r == short_row && c == len - 1) lock_short_end = locked_out;
                if (r == short_row + 1 && c == 0) lock_after_short = locked_out;
                n_valid += int'(valid_out);
                n_fs    += int'(fs_out);
                if (int'(col_out) != c || int'(row_out) != r) n_pos_bad++;
                exp_win = (c < AC) && (r < AR);
                if (valid_out != exp_win) n_win_bad++;
                if (valid_out) begin
                    if (red_out != RED_PIX || grn_out != GRN_PIX || blu_out != BLU_PIX) n_rgb_bad++;
                end else begin
                    if (red_out != '0 || grn_out != '0 || blu_out != '0) n_rgb_bad++;
                end
            end
        end
        $display("frame rows=%0d valid=%0d fs=%0d lock_first=%0d err=%0d",
                 rows, n_valid, n_fs, lock_first, err_out);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            hsync = 1'b0;
            vsync = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_col",    int'(col_out),    0);
        chk("rst_row",    int'(row_out),    0);
        chk("rst_locked", int'(locked_out), 0);
        chk("rst_valid",  int'(valid_out),  0);
        chk("rst_fs",     int'(fs_out),     0);
        chk("rst_err",    int'(err_out),    0);
        @(negedge clk);
        rst_n = 1'b1;

        // Acquire: SEARCH -> TRACK -> good 1 -> LOCKED on third VSync edge
        drive_frame(TR, -1, 0);
        chk("f1_lock_first", int'(lock_first), 0);
        chk("f1_fs",         n_fs,             1);
        chk("f1_pos_bad",    n_pos_bad,        0);
        chk("f1_valid",      n_valid,          0);
        drive_frame(TR, -1, 0);
        chk("f2_lock_first", int'(lock_first), 0);
        drive_frame(TR, -1, 0);
        chk("f3_lock_first", int'(lock_first), 1);
        chk("f3_valid",      n_valid,          AC * AR);
        chk("f3_win_bad",    n_win_bad,        0);
        chk("f3_rgb_bad",    n_rgb_bad,        0);
        chk("f3_pos_bad",    n_pos_bad,        0);
        chk("f3_err",        int'(err_out),    0);

        // Row 4 one clock short: error at the start of row 5
        drive_frame(TR, 4, TC - 1);
        chk("short_lock_before", int'(lock_short_end),   1);
        chk("short_lock_after",  int'(lock_after_short), 0);
        chk("short_valid",       n_valid,                5 * AC);
        chk("short_err",         int'(err_out),          1);
        drive_frame(TR, -1, 0);
        chk("re1_lock_first", int'(lock_first), 0);
        drive_frame(TR, -1, 0);
        chk("re2_lock_first", int'(lock_first), 0);
        drive_frame(TR, -1, 0);
        chk("re3_lock_first", int'(lock_first), 1);
        chk("re3_err",        int'(err_out),    1);

        // HSync stuck low: one timeout, column saturates
        drive_frame(1, -1, 0);
        chk("to_lock_first", int'(lock_first), 1);
        idle_cycles(1100);
        chk("to_col_sat", int'(col_out),    1023);
        chk("to_err",     int'(err_out),    2);
        chk("to_locked",  int'(locked_out), 0);

        drive_frame(TR, -1, 0);
        chk("a_lock_first", int'(lock_first), 0);
        chk("a_pos_bad",    n_pos_bad,        0);
        chk("a_err",        int'(err_out),    2);
        drive_frame(TR, -1, 0);
        drive_frame(TR - 1, -1, 0);
        chk("c_lock_first", int'(lock_first), 1);
        chk("c_valid",      n_valid,          AC * AR);

        // Next VSync edge after the short frame is a frame error
        drive_frame(TR, -1, 0);
        chk("d_lock_first", int'(lock_first), 0);
        chk("d_fs",         n_fs,             1);
        chk("d_err",        int'(err_out),    3);

        drive_frame(TR, -1, 0);
        drive_frame(TR, -1, 0);
        drive_frame(4, 3, 8);
        chk("g_lock_first", int'(lock_first),     1);
        chk("g_lock_mid",   int'(lock_short_end), 1);

        // Asynchronous reset mid-line
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_col",    int'(col_out),    0);
        chk("arst_row",    int'(row_out),    0);
        chk("arst_locked", int'(locked_out), 0);
        chk("arst_valid",  int'(valid_out),  0);
        chk("arst_err",    int'(err_out),    0);
        chk("arst_red",    int'(red_out),    0);
        idle_cycles(2);
        @(negedge clk);
        rst_n = 1'b1;
        drive_frame(TR, -1, 0);
        chk("h_lock_first", int'(lock_first), 0);
        chk("h_pos_bad",    n_pos_bad,        0);
        chk("h_valid",      n_valid,          0);
        chk("h_err",        int'(err_out),    0);
        chk("h_locked_end", int'(locked_out), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
